debug_dump_tx: RTL

//   Reads the debug monitor's 32-bit debug words and transmits them to the host side.
//   On a trigger it snapshots all words, then streams them as a framed byte packet on a

---
 rtl/dbg_pkg.sv | 6 +
 rtl/debug_dump_tx.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dbg_pkg.sv
// dbg_pkg: shared state encoding and framing constants for debug_dump_tx.
package dbg_pkg;
    typedef enum logic [2:0] {IDLE, HDR, LEN, DATA, CSUM} dbg_tx_state_e;
    localparam logic [7:0] DBG_HDR    = 8'hA5;
    localparam int         DBG_BYTE_W = 8;
endpackage

// File: rtl/debug_dump_tx.sv
// debug_dump_tx: snapshots debug words on trigger and streams them as a framed byte packet.
// DBG_CHECKSUM_EN appends an XOR checksum byte over LEN and data bytes.
module debug_dump_tx
    import dbg_pkg::*;
#(
    parameter int NUM_WORDS = 3,
    parameter int WORD_W    = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                trig_i,
    input  logic [NUM_WORDS-1:0][WORD_W-1:0]    dbg_words_i,
    output logic                                busy_o,
    output logic                                tx_vld_o,
    output logic [7:0]                          tx_data_o,
    output logic                                tx_last_o,
    input  logic                                tx_rdy_i,
    output logic [7:0]                          drop_cnt_o
);
    localparam logic [7:0] LEN_B = 8'(NUM_WORDS * WORD_W / DBG_BYTE_W);
`ifdef DBG_CHECKSUM_EN
    localparam logic DATA_LAST = 1'b0;
`else
    localparam logic DATA_LAST = 1'b1;
`endif

    dbg_tx_state_e                   state_q, state_d;
    logic [7:0]                      idx_q, idx_d;
    logic [NUM_WORDS*WORD_W-1:0]     snap_q, snap_d;
    logic                            vld_q, vld_d;
    logic [7:0]                      data_q, data_d;
    logic                            last_q, last_d;
    logic [7:0]                      drop_q, drop_d;
    logic                            hs;
`ifdef DBG_CHECKSUM_EN
    logic [7:0]                      csum_q, csum_d;
`endif

    assign hs = vld_q & tx_rdy_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        vld_d   = vld_q;
        data_d  = data_q;
        last_d  = last_q;
        drop_d  = (state_q != IDLE && trig_i && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
`ifdef DBG_CHECKSUM_EN
        // The byte on the bus is folded in as it is accepted, so csum_q ^ data_q is the full sum.
        csum_d  = (state_q == IDLE) ? 8'h00 :
                  (hs && (state_q == LEN || state_q == DATA)) ? csum_q ^ data_q : csum_q;
`endif
        case (state_q)
            IDLE: if (trig_i) begin
                state_d = HDR;
                snap_d  = dbg_words_i;
                vld_d   = 1'b1;
                data_d  = DBG_HDR;
                last_d  = 1'b0;
                idx_d   = 8'd0;
            end
            HDR: if (hs) begin
                state_d = LEN;
                data_d  = LEN_B;
            end
            LEN: if (hs) begin
                state_d = DATA;
                idx_d   = 8'd0;
                data_d  = snap_q[DBG_BYTE_W-1:0];
                last_d  = DATA_LAST & (LEN_B == 8'd1);
            end
            DATA: if (hs) begin
                if (idx_q == LEN_B - 8'd1) begin
`ifdef DBG_CHECKSUM_EN
                    state_d = CSUM;
                    data_d  = csum_q ^ data_q;
                    last_d  = 1'b1;
`else
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    data_d  = 8'h00;
                    last_d  = 1'b0;
`endif
                end else begin
                    idx_d  = idx_q + 8'd1;
                    data_d = snap_q[DBG_BYTE_W*int'(idx_d) +: DBG_BYTE_W];
                    last_d = DATA_LAST & (idx_d == LEN_B - 8'd1);
                end
            end
`ifdef DBG_CHECKSUM_EN
            CSUM: if (hs) begin
                state_d = IDLE;
                vld_d   = 1'b0;
                data_d  = 8'h00;
                last_d  = 1'b0;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            drop_q  <= '0;
`ifdef DBG_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
`ifdef DBG_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign tx_vld_o   = vld_q;
    assign tx_data_o  = data_q;
    assign tx_last_o  = last_q;
    assign drop_cnt_o = drop_q;
endmodule
